// File: rtl/gumnut_ctrl_if.sv
// gumnut_ctrl_if: instruction, data, ALU and PC signals between the Gumnut control unit and its datapath
interface gumnut_ctrl_if #(
    parameter int IW = 18,
    parameter int AW = 12
);
    logic [IW-1:0] inst;
    logic          inst_req;
    logic          inst_ack;
    logic          data_req;
    logic          data_we;
    logic          data_io;
    logic          data_ack;
    logic [3:0]    alu_op;
    logic [2:0]    alu_count;
    logic          alu_cin;
    logic          alu_cout;
    logic          alu_zero;
    logic          op2_imm;
    logic [2:0]    rd;
    logic [2:0]    rs;
    logic [2:0]    r2;
    logic [7:0]    imm;
    logic          reg_we;
    logic          wb_mem;
    logic          pc_inc;
    logic          pc_load;
    logic [AW-1:0] pc_target;
    logic          pc_rel;
    logic          illegal;
    logic          halted;

    modport master (
        input  inst, inst_ack, data_ack, alu_cout, alu_zero,
        output inst_req, data_req, data_we, data_io, alu_op, alu_count, alu_cin,
               op2_imm, rd, rs, r2, imm, reg_we, wb_mem, pc_inc, pc_load,
               pc_target, pc_rel, illegal, halted
    );

    modport slave (
        output inst, inst_ack, data_ack, alu_cout, alu_zero,
        input  inst_req, data_req, data_we, data_io, alu_op, alu_count, alu_cin,
               op2_imm, rd, rs, r2, imm, reg_we, wb_mem, pc_inc, pc_load,
               pc_target, pc_rel, illegal, halted
    );
endinterface

// File: rtl/gumnut_ctrl.sv
// gumnut_ctrl: multicycle fetch/decode/execute sequencer and C/Z flag register for the Gumnut core
module gumnut_ctrl #(
    parameter int IW = 18,
    parameter int AW = 12
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    gumnut_ctrl_if.master bus
);
    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WRITE, HALT} state_t;

    state_t        state, state_nx;
    logic          run;
    logic [IW-1:0] ir;
    logic          c_flag, z_flag;
    logic          is_alui, is_alur, is_shift, is_mem, is_br, is_jmp, is_stby, is_alu, is_ill;
    logic          act, fetched, br_take;

    assign is_alui  = !ir[17];
    assign is_mem   = ir[17:16] == 2'b10;
    assign is_shift = ir[17:15] == 3'b110;
    assign is_alur  = ir[17:14] == 4'b1110;
    assign is_jmp   = ir[17:12] == 6'b111100;
    assign is_br    = ir[17:12] == 6'b111110;
    assign is_stby  = ir[17:11] == 7'b1111110 && ir[10:8] == 3'b101;
    assign is_alu   = is_alui || is_alur || is_shift;
    assign is_ill   = !(is_alu || is_mem || is_br || is_jmp || is_stby);
    assign act      = state inside {DECODE, EXECUTE, MEM, WRITE};
    assign fetched  = state == FETCH && run && bus.inst_ack;
    assign br_take  = ir[11] ? (ir[10] ? !c_flag : c_flag) : (ir[10] ? !z_flag : z_flag);

    // state register; run holds requests off for the first cycle after reset release
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= FETCH;
            run   <= 1'b0;
        end else begin
            state <= state_nx;
            run   <= 1'b1;
        end
    end

    // instruction register and flags, which only ALU/shift execution may update
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ir     <= '0;
            c_flag <= 1'b0;
            z_flag <= 1'b0;
        end else begin
            if (fetched)
                ir <= bus.inst;
            if (state == EXECUTE && is_alu) begin
                c_flag <= bus.alu_cout;
                z_flag <= bus.alu_zero;
            end
        end
    end

    // next-state sequencing and decoded outputs; fields stay zero outside an active instruction
    always_comb begin
        state_nx      = state;
        bus.inst_req  = state == FETCH && run;
        bus.pc_inc    = fetched;
        bus.data_req  = state == MEM;
        bus.data_we   = state == MEM && ir[14];
        bus.data_io   = state == MEM && ir[15];
        bus.reg_we    = state == WRITE && ir[13:11] != 3'd0;
        bus.wb_mem    = state == WRITE && is_mem;
        bus.pc_load   = state == EXECUTE && (is_jmp || (is_br && br_take));
        bus.pc_rel    = act && is_br;
        bus.pc_target = !act ? '0 :
                        is_br ? {{(AW-8){ir[7]}}, ir[7:0]} :
                        is_jmp ? ir[AW-1:0] : '0;
        bus.illegal   = state == EXECUTE && is_ill;
        bus.halted    = state == HALT;
        bus.alu_cin   = c_flag;
        bus.alu_op    = !act ? 4'd0 :
                        is_alui ? {1'b0, ir[16:14]} :
                        is_alur ? {1'b0, ir[2:0]} :
                        is_shift ? {2'b10, ir[1:0]} : 4'd0;
        bus.alu_count = act && is_shift ? ir[7:5] : 3'd0;
        bus.op2_imm   = act && (is_alui || is_mem);
        bus.rd        = act ? ir[13:11] : 3'd0;
        bus.rs        = act ? ir[10:8] : 3'd0;
        bus.r2        = act ? ir[7:5] : 3'd0;
        bus.imm       = act ? ir[7:0] : 8'd0;
        case (state)
            FETCH:   state_nx = fetched ? DECODE : FETCH;
            DECODE:  state_nx = EXECUTE;
            EXECUTE: state_nx = is_alu ? WRITE : is_mem ? MEM : is_stby ? HALT : FETCH;
            MEM:     state_nx = !bus.data_ack ? MEM : ir[14] ? FETCH : WRITE;
            WRITE:   state_nx = FETCH;
            HALT:    state_nx = HALT;
            default: state_nx = FETCH;
        endcase
    end
endmodule
